// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt request controller.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Width of a source id; a two-source controller still needs one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Index of the lowest set bit (lowest index = highest priority); 0 when none set.
    function automatic int lowest_set(input logic [15:0] v);
        int idx;
        idx = 0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/intc_sync_edge.sv
// One interrupt line: SYNC_STAGES-deep synchroniser, previous-value flop and
// single-cycle rising-edge pulse.  The previous-value flop resets to 0, so a
// line held high through reset produces exactly one edge after release.
module intc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Shift the async line through the synchroniser and remember the last synced value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt request controller: per-source edge capture into pending bits,
// mask, lowest-index priority and an IDLE/REQ/SERVICE handshake with the core.
// Optional build macro INTC_TIMEOUT_EN withdraws an unacknowledged request
// after ACK_TIMEOUT cycles and raises the sticky timeout flag.
module int_ctrl
    import intc_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          irq_in,
    input  logic [N_SRC-1:0]          mask,
    input  logic                      ack,
    input  logic                      eoi,
    output logic                      INT,
    output logic [id_w(N_SRC)-1:0]    irq_id,
    output logic                      busy,
    output logic [N_SRC-1:0]          pending,
    output logic                      timeout
);

    localparam int ID_W = id_w(N_SRC);

    if (N_SRC < 2 || N_SRC > 16 || SYNC_STAGES < 2 || ACK_TIMEOUT < 1) begin : g_bad_params
        $error("int_ctrl: parameter out of range");
    end

    state_t            state_reg;
    logic              int_reg;
    logic [ID_W-1:0]   irq_id_reg;
    logic              busy_reg;
    logic [N_SRC-1:0]  pending_reg;
    logic [N_SRC-1:0]  pending_next;
    logic [N_SRC-1:0]  rise_vec;
    logic [N_SRC-1:0]  req_vec;
    logic [N_SRC-1:0]  clr_vec;
    logic [15:0]       req_ext;
    logic [ID_W-1:0]   winner;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            intc_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync_edge (
                .clk  (clk),
                .rst  (rst),
                .din  (irq_in[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    assign req_vec = pending_reg & mask;
    assign req_ext = 16'(req_vec);
    assign winner  = ID_W'(lowest_set(req_ext));

    // Clear the acknowledged source; a new edge in the same cycle re-sets it.
    always_comb begin
        clr_vec = '0;
        if (state_reg == REQ && ack) clr_vec[irq_id_reg] = 1'b1;
        pending_next = (pending_reg & ~clr_vec) | rise_vec;
    end

    // Pending bits: captured regardless of mask, dropped only on acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_reg <= '0;
        else     pending_reg <= pending_next;
    end

`ifdef INTC_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;
`endif

    // Request handshake FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            int_reg     <= 1'b0;
            irq_id_reg  <= '0;
            busy_reg    <= 1'b0;
`ifdef INTC_TIMEOUT_EN
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        state_reg  <= REQ;
                        int_reg    <= 1'b1;
                        irq_id_reg <= winner;
`ifdef INTC_TIMEOUT_EN
                        cnt_reg    <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ack) begin
                        state_reg <= SERVICE;
                        int_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                    end else if (!mask[irq_id_reg]) begin
                        state_reg <= IDLE;
                        int_reg   <= 1'b0;
                    end
`ifdef INTC_TIMEOUT_EN
                    else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state_reg   <= IDLE;
                        int_reg     <= 1'b0;
                        timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
`endif
                end
                SERVICE: begin
                    if (eoi) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    int_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign INT     = int_reg;
    assign irq_id  = irq_id_reg;
    assign busy    = busy_reg;
    assign pending = pending_reg;
`ifdef INTC_TIMEOUT_EN
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

endmodule
